// File: rtl/l2_flush_sequencer.sv
// rtl/l2_flush_sequencer.sv - walks every L2 set/way, writing back owned lines and invalidating them
module l2_flush_sequencer #(
   parameter int SETS     = 256,
   parameter int WAYS     = 8,
   parameter int SET_BITS = $clog2(SETS),
   parameter int WAY_BITS = $clog2(WAYS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_valid,
   input  logic                flush_is_all,
   output logic                flush_ready,
   input  logic                mshr_empty,
   input  logic                fwd_pending,
   output logic                rd_en,
   output logic [SET_BITS-1:0] rd_set,
   input  logic [WAYS-1:0]     way_owned,
   input  logic [WAYS-1:0]     way_valid,
   output logic                wb_valid,
   input  logic                wb_ready,
   output logic [SET_BITS-1:0] wb_set,
   output logic [WAY_BITS-1:0] wb_way,
   output logic                wb_dirty,
   output logic                inv_en,
   output logic                flush_ongoing,
   output logic                flush_done
);
   typedef enum logic [2:0] {IDLE, DRAIN, READ, LATCH, SCAN, WB, DONE} state_t;

   state_t              state, state_d;
   logic [SET_BITS-1:0] set_cnt, set_d;
   logic [WAY_BITS-1:0] way_cnt, way_d;
   logic [WAYS-1:0]     own_q, own_d, val_q, val_d;
   logic                all_q, all_d;
   logic                need, advance, last_way, last_set;

   assign last_way = (way_cnt == WAY_BITS'(WAYS - 1));
   assign last_set = (set_cnt == SET_BITS'(SETS - 1));
   assign need     = own_q[way_cnt] | (all_q & val_q[way_cnt]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         set_cnt <= '0;
         way_cnt <= '0;
         own_q   <= '0;
         val_q   <= '0;
         all_q   <= 1'b0;
      end else begin
         state   <= state_d;
         set_cnt <= set_d;
         way_cnt <= way_d;
         own_q   <= own_d;
         val_q   <= val_d;
         all_q   <= all_d;
      end
   end

   always_comb begin
      state_d = state;
      set_d   = set_cnt;
      way_d   = way_cnt;
      own_d   = own_q;
      val_d   = val_q;
      all_d   = all_q;
      advance = 1'b0;
      case (state)
         IDLE: begin
            if (flush_valid) begin
               all_d   = flush_is_all;
               set_d   = '0;
               way_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (mshr_empty && !fwd_pending) state_d = READ;
         end
         READ:  state_d = LATCH;
         LATCH: begin
            own_d   = way_owned;
            val_d   = way_valid;
            state_d = SCAN;
         end
         SCAN: begin
            // a forward may have changed line states, so the same set is re-read
            if (fwd_pending)  state_d = READ;
            else if (need)    state_d = WB;
            else              advance = 1'b1;
         end
         WB: begin
            if (wb_ready) advance = 1'b1;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (advance) begin
         if (!last_way) begin
            way_d   = way_cnt + 1'b1;
            state_d = SCAN;
         end else begin
            way_d = '0;
            if (last_set) begin
               state_d = DONE;
            end else begin
               set_d   = set_cnt + 1'b1;
               state_d = READ;
            end
         end
      end
   end

   assign flush_ready   = (state == IDLE);
   assign rd_en         = (state == READ);
   assign rd_set        = set_cnt;
   assign wb_valid      = (state == WB);
   assign wb_set        = set_cnt;
   assign wb_way        = way_cnt;
   assign wb_dirty      = wb_valid & own_q[way_cnt];
   assign inv_en        = wb_valid & wb_ready;
   assign flush_ongoing = (state != IDLE) && (state != DONE);
   assign flush_done    = (state == DONE);
endmodule

// File: tb/tb_l2_flush_sequencer.sv
// tb/tb_l2_flush_sequencer.sv - randomized and directed bench with a line-level cache model
module tb_l2_flush_sequencer;
   localparam int SETS = 4;
   localparam int WAYS = 4;
   localparam int N    = SETS * WAYS;

   logic       clk = 1'b0;
   logic       rst, flush_valid, flush_is_all, flush_ready, mshr_empty, fwd_pending;
   logic       rd_en, wb_valid, wb_ready, wb_dirty, inv_en, flush_ongoing, flush_done;
   logic [1:0] rd_set, wb_set, wb_way;
   logic [3:0] way_owned = '0, way_valid = '0;

   l2_flush_sequencer #(.SETS(SETS), .WAYS(WAYS)) dut (
      .clk(clk), .rst(rst), .flush_valid(flush_valid), .flush_is_all(flush_is_all),
      .flush_ready(flush_ready), .mshr_empty(mshr_empty), .fwd_pending(fwd_pending),
      .rd_en(rd_en), .rd_set(rd_set), .way_owned(way_owned), .way_valid(way_valid),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_set(wb_set), .wb_way(wb_way),
      .wb_dirty(wb_dirty), .inv_en(inv_en), .flush_ongoing(flush_ongoing), .flush_done(flush_done)
   );

   always #5 clk = ~clk;

   // stimulus-owned
   int tid = 0, load_seq = 0, mut_seq = 0, mut_idx = 0;
   bit rand_mut = 0, mut_own = 0, mut_val = 0;
   bit ld_own [N];
   bit ld_val [N];

   // checker-owned
   int tests = 0, fails = 0, cyc = 0, done_cnt = 0, load_seen = 0, mut_seen = 0;
   int acc_cyc = 0, first_rd_cyc = 0, ptr = 0, last_read = -1;
   int rd_cnt = 0, wb_cnt = 0, wb_cycles = 0, inv_cnt = 0;
   int f_set = 0, f_way = 0, f_dirty = 0, i_set = 0, i_way = 0, h_pack = 0;
   bit active = 0, all_exp = 0, read_seen = 0, drain_due = 0, fwd_since_read = 0;
   bit fwd_any = 0, wb_hold = 0, fwd_prev = 0;
   bit mem_own [N];
   bit mem_val [N];
   bit snap_own [N];
   bit snap_val [N];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // first line at or after 'from' that the flush must write back, by the latest read of its set
   function automatic int find_need(input int from, input int upto);
      for (int p = from; p < upto; p++)
         if (snap_own[p] || (all_exp && snap_val[p])) return p;
      return -1;
   endfunction

   always @(negedge clk) begin : compare
      int ex, p;
      cyc++;
      if (load_seq != load_seen) begin
         load_seen = load_seq;
         for (int i = 0; i < N; i++) begin
            mem_own[i] = ld_own[i];
            mem_val[i] = ld_val[i] | ld_own[i];
         end
      end
      if (mut_seq != mut_seen) begin
         mut_seen = mut_seq;
         mem_own[mut_idx] = mut_own;
         mem_val[mut_idx] = mut_val | mut_own;
      end

      if (rst) begin
         chk("reset_outputs", int'({flush_ready, rd_en, wb_valid, inv_en, flush_ongoing, flush_done,
                                    wb_dirty, rd_set, wb_set, wb_way}), 4096);
         active = 0; wb_hold = 0; drain_due = 0;
      end else begin
         chk("flush_ready", int'(flush_ready), int'(!active));
         if (flush_done) chk("flush_ongoing_done", int'(flush_ongoing), 0);
         else            chk("flush_ongoing", int'(flush_ongoing), int'(active));
         chk("inv_en", int'(inv_en), int'(wb_valid & wb_ready));

         if (!active) begin
            chk("idle_quiet", int'({rd_en, wb_valid, flush_done}), 0);
            if (flush_valid) begin
               active = 1; acc_cyc = cyc; all_exp = flush_is_all; ptr = 0; last_read = -1;
               read_seen = 0; drain_due = 0; fwd_since_read = 0; fwd_any = 0;
               rd_cnt = 0; wb_cnt = 0; wb_cycles = 0; inv_cnt = 0; wb_hold = 0;
            end
         end else begin
            if (!read_seen) begin
               chk("drain_read", int'(rd_en), int'(drain_due));
               drain_due = mshr_empty && !fwd_pending;
            end
            if (rd_en) begin
               if (!read_seen) begin
                  chk("first_rd_set", int'(rd_set), 0);
                  read_seen = 1; first_rd_cyc = cyc;
               end else if (int'(rd_set) == last_read) begin
                  chk("reread_cause", int'(fwd_since_read), 1);
               end else begin
                  chk("rd_set_order", int'(rd_set), last_read + 1);
                  chk("missed_wb", find_need(ptr, (last_read + 1) * WAYS), -1);
               end
               last_read = int'(rd_set); rd_cnt++; fwd_since_read = 0;
               for (int w = 0; w < WAYS; w++) begin
                  snap_own[last_read*WAYS+w] = mem_own[last_read*WAYS+w];
                  snap_val[last_read*WAYS+w] = mem_val[last_read*WAYS+w];
                  way_owned[w] = mem_own[last_read*WAYS+w];
                  way_valid[w] = mem_val[last_read*WAYS+w];
               end
            end else if (read_seen && fwd_pending) begin
               fwd_since_read = 1;
            end
            if (read_seen && fwd_pending && !wb_valid) fwd_any = 1;

            if (rand_mut && fwd_pending && !fwd_prev && last_read < SETS - 1) begin
               p = int'($urandom_range(SETS - 1, last_read + 1)) * WAYS + int'($urandom_range(WAYS - 1, 0));
               mem_own[p] = 1'($urandom % 2);
               mem_val[p] = mem_own[p] | 1'($urandom % 2);
            end

            if (wb_valid) begin
               if (wb_hold) begin
                  chk("wb_stable", int'({wb_set, wb_way, wb_dirty}), h_pack);
               end else begin
                  ex = find_need(ptr, (last_read + 1) * WAYS);
                  chk("wb_expected", int'(ex >= 0), 1);
                  if (ex >= 0) begin
                     chk("wb_set", int'(wb_set), ex / WAYS);
                     chk("wb_way", int'(wb_way), ex % WAYS);
                     chk("wb_dirty", int'(wb_dirty), int'(snap_own[ex]));
                     ptr = ex + 1;
                  end
                  if (wb_cnt == 0) begin
                     f_set = int'(wb_set); f_way = int'(wb_way); f_dirty = int'(wb_dirty);
                  end
                  wb_cnt++;
               end
               wb_cycles++;
               wb_hold = !wb_ready;
               h_pack  = int'({wb_set, wb_way, wb_dirty});
               if (wb_ready) begin
                  inv_cnt++;
                  if (inv_cnt == 1) begin i_set = int'(wb_set); i_way = int'(wb_way); end
                  mem_own[int'(wb_set)*WAYS+int'(wb_way)] = 0;
                  mem_val[int'(wb_set)*WAYS+int'(wb_way)] = 0;
               end
            end else begin
               if (wb_hold) chk("wb_withdrawn", int'(wb_valid), 1);
               wb_hold = 0;
            end

            if (flush_done) begin
               chk("done_last_set", last_read, SETS - 1);
               chk("done_pending_wb", find_need(ptr, N), -1);
               if (!fwd_any) chk("done_latency", cyc - first_rd_cyc, SETS * (2 + WAYS) + wb_cycles);
               case (tid)
                  1: begin chk("t1_latency", cyc - acc_cyc, 26); chk("t1_wb_count", wb_cnt, 0); end
                  2: begin
                     chk("t2_latency", cyc - acc_cyc, 27); chk("t2_wb_count", wb_cnt, 1);
                     chk("t2_wb_set", f_set, 2); chk("t2_wb_way", f_way, 3); chk("t2_wb_dirty", f_dirty, 1);
                     chk("t2_inv_count", inv_cnt, 1); chk("t2_inv_line", i_set * 4 + i_way, 11);
                  end
                  3: begin
                     chk("t3_latency", cyc - acc_cyc, 27); chk("t3_wb_count", wb_cnt, 1);
                     chk("t3_wb_line", f_set * 4 + f_way, 4); chk("t3_wb_dirty", f_dirty, 0);
                  end
                  4: begin
                     chk("t4_latency", cyc - acc_cyc, 32); chk("t4_wb_cycles", wb_cycles, 6);
                     chk("t4_wb_line", f_set * 4 + f_way, 1); chk("t4_wb_dirty", f_dirty, 1);
                  end
                  5: begin
                     chk("t5_latency", cyc - acc_cyc, 30); chk("t5_rd_count", rd_cnt, 5);
                     chk("t5_wb_count", wb_cnt, 1); chk("t5_wb_line", f_set * 4 + f_way, 14);
                     chk("t5_wb_dirty", f_dirty, 1);
                  end
                  6: begin
                     chk("t6_first_read", first_rd_cyc - acc_cyc, 12);
                     chk("t6_latency", cyc - acc_cyc, 36);
                  end
                  8: begin chk("t8_latency", cyc - acc_cyc, 26); chk("t8_wb_count", wb_cnt, 0); end
                  default: ;
               endcase
               done_cnt++; active = 0;
            end else if (cyc - acc_cyc > 2000) begin
               chk("flush_timeout", cyc - acc_cyc, 2000);
               done_cnt++; active = 0;
            end
         end
      end
      fwd_prev = fwd_pending;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic load_clear();
      for (int i = 0; i < N; i++) begin ld_own[i] = 0; ld_val[i] = 0; end
   endtask

   task automatic load_commit();
      load_seq++;
      tick();
   endtask

   task automatic do_flush(input int t, input bit all);
      tid = t; flush_is_all = all; flush_valid = 1;
      tick();
      flush_valid = 0;
   endtask

   task automatic wait_done();
      int start;
      start = done_cnt;
      for (int i = 0; i < 3000 && done_cnt == start; i++) tick();
      tick();
   endtask

   task automatic wait_wb();
      for (int i = 0; i < 200 && !wb_valid; i++) tick();
   endtask

   initial begin
      int start;
      bit fen;
      rst = 1; flush_valid = 0; flush_is_all = 0; mshr_empty = 1; fwd_pending = 0; wb_ready = 1;
      load_clear();
      repeat (3) @(posedge clk);
      #1 rst = 0;
      tick();

      load_clear(); load_commit(); do_flush(1, 1); wait_done();

      load_clear(); ld_own[2*4+3] = 1; ld_val[1*4+0] = 1; load_commit();
      do_flush(2, 0); wait_done();

      load_clear(); ld_val[1*4+0] = 1; load_commit(); do_flush(3, 1); wait_done();
      load_clear(); ld_val[1*4+0] = 1; load_commit(); do_flush(8, 0); wait_done();

      load_clear(); ld_own[0*4+1] = 1; load_commit();
      wb_ready = 0; do_flush(4, 0); wait_wb();
      tick(); fwd_pending = 1; tick(); tick(); fwd_pending = 0; tick(); tick(); wb_ready = 1;
      wait_done();

      load_clear(); load_commit(); do_flush(5, 1);
      repeat (22) tick();
      fwd_pending = 1; mut_idx = 3*4+2; mut_own = 1; mut_val = 1; mut_seq++;
      tick(); fwd_pending = 0; wait_done();

      load_clear(); load_commit(); mshr_empty = 0; do_flush(6, 0);
      repeat (10) tick();
      mshr_empty = 1; wait_done();

      load_clear(); ld_own[0] = 1; load_commit();
      wb_ready = 0; do_flush(7, 1); wait_wb();
      tick(); rst = 1; tick(); tick(); rst = 0; wb_ready = 1; tick();

      for (int r = 0; r < 14; r++) begin
         load_clear();
         for (int i = 0; i < N; i++) begin
            ld_own[i] = ($urandom % 4 == 0);
            ld_val[i] = 1'($urandom % 2);
         end
         load_commit();
         fen = 1'(r % 2); rand_mut = fen;
         do_flush(0, 1'($urandom % 2));
         start = done_cnt;
         for (int i = 0; i < 3000 && done_cnt == start; i++) begin
            wb_ready     = ($urandom % 3 != 0);
            fwd_pending  = fen && ($urandom % 12 == 0);
            mshr_empty   = ($urandom % 4 != 0);
            flush_valid  = flush_ongoing && ($urandom % 10 == 0);
            flush_is_all = 1'($urandom % 2);
            tick();
         end
         flush_valid = 0; fwd_pending = 0; mshr_empty = 1; wb_ready = 1; rand_mut = 0;
         tick();
      end

      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
